// File: rtl/tcb_gpio_pkg.sv
// Shared types and default widths for the GPIO input-conditioning blocks.
// tcb_gpio_dbc_bit_t holds one bit's filter state: the stability counter and the accepted level.
package tcb_gpio_pkg;

  localparam int unsigned GPIO_GW = 32;
  localparam int unsigned GPIO_CW = 8;

  typedef struct packed {
    logic [GPIO_CW-1:0] cfg_len;
  } tcb_gpio_dbc_cfg_t;

  typedef struct packed {
    logic [GPIO_CW-1:0] cnt;
    logic               flt;
  } tcb_gpio_dbc_bit_t;

endpackage : tcb_gpio_pkg

// File: rtl/tcb_gpio_debounce_bit.sv
// One-bit stability filter: a changed level is accepted after it has held cfg_len+1 cycles.
// On acceptance it emits a registered rise or fall pulse in the same cycle the filtered level changes.
module tcb_gpio_debounce_bit
  import tcb_gpio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  tcb_gpio_dbc_cfg_t cfg_i,
  input  logic              syn_i,
  output logic              flt_o,
  output logic              rise_o,
  output logic              fall_o
);

  tcb_gpio_dbc_bit_t st_q, st_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    st_d   = st_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (syn_i == st_q.flt) begin
      st_d.cnt = '0;
    end else if (st_q.cnt >= cfg_i.cfg_len) begin
      // >= rather than == so lowering cfg_len mid-count still accepts on the next cycle
      st_d.flt = syn_i;
      st_d.cnt = '0;
      rise_d   = syn_i;
      fall_d   = ~syn_i;
    end else begin
      st_d.cnt = st_q.cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      st_q   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign flt_o  = st_q.flt;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : tcb_gpio_debounce_bit

// File: rtl/tcb_gpio_debounce.sv
// GPIO input conditioning: CFG_CDC-stage synchronizer, per-bit glitch filter, rise/fall pulses.
// Define TCB_GPIO_DEBOUNCE_IRQ_EN to add sticky edge status and a level irq output. CW must not exceed GPIO_CW.
module tcb_gpio_debounce
  import tcb_gpio_pkg::*;
#(
  parameter int unsigned GW      = GPIO_GW,
  parameter int unsigned CW      = GPIO_CW,
  parameter int unsigned CFG_CDC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg_len,
  input  logic [GW-1:0] gpio_i,
`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
  input  logic [GW-1:0] irq_ena,
  input  logic [GW-1:0] irq_clr,
  output logic [GW-1:0] irq_sts,
  output logic          irq,
`endif
  output logic [GW-1:0] flt_o,
  output logic [GW-1:0] rise_o,
  output logic [GW-1:0] fall_o
);

  logic [GW-1:0]     syn;
  tcb_gpio_dbc_cfg_t cfg;

  assign cfg.cfg_len = GPIO_CW'(cfg_len);

  generate
    if (CFG_CDC == 0) begin : g_no_cdc
      assign syn = gpio_i;
    end else begin : g_cdc
      logic [GW-1:0] syn_q [CFG_CDC];

      always_ff @(posedge clk) begin
        // NOTE: the synchronizer chain is a handful of flops, not a RAM, so it is reset with everything else.
        if (rst) begin
          for (int i = 0; i < CFG_CDC; i++) syn_q[i] <= '0;
        end else begin
          syn_q[0] <= gpio_i;
          for (int i = 1; i < CFG_CDC; i++) syn_q[i] <= syn_q[i-1];
        end
      end

      assign syn = syn_q[CFG_CDC-1];
    end
  endgenerate

  for (genvar g = 0; g < GW; g++) begin : g_bit
    tcb_gpio_debounce_bit u_bit (
      .clk    (clk),
      .rst    (rst),
      .cfg_i  (cfg),
      .syn_i  (syn[g]),
      .flt_o  (flt_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g])
    );
  end

`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
  logic [GW-1:0] irq_sts_q, irq_sts_d;
  logic          irq_q;

  // a new enabled edge sets status even when a clear arrives in the same cycle
  always_comb irq_sts_d = (irq_sts_q & ~irq_clr) | ((rise_o | fall_o) & irq_ena);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sts_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_sts_q <= irq_sts_d;
      irq_q     <= |irq_sts_q;
    end
  end

  assign irq_sts = irq_sts_q;
  assign irq     = irq_q;
`endif

endmodule : tcb_gpio_debounce

// File: tb/tb_tcb_gpio_debounce.sv
// Directed bench for tcb_gpio_debounce with CFG_CDC=2 and cfg_len=3 (0 for the pass-through case).
// IRQ scenarios run when TCB_GPIO_DEBOUNCE_IRQ_EN is defined for the build.
module tb_tcb_gpio_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_len;
  logic [31:0] gpio_i;
  logic [31:0] flt_o, rise_o, fall_o;
`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
  logic [31:0] irq_ena, irq_clr, irq_sts;
  logic        irq;
`endif

  int   checks = 0;
  int   errors = 0;
  int   rise_cycles = 0;
  int   fall_cycles = 0;
  logic excl_bad = 1'b0;

  logic [31:0] drv [10];
  logic [6:0]  pat;

  always #5 clk = ~clk;

  tcb_gpio_debounce #(.GW(32), .CW(8), .CFG_CDC(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_len (cfg_len),
    .gpio_i  (gpio_i),
`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
    .irq_ena (irq_ena),
    .irq_clr (irq_clr),
    .irq_sts (irq_sts),
    .irq     (irq),
`endif
    .flt_o   (flt_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n cycles; outputs are observed on the falling edge, inputs change right after.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (|rise_o) rise_cycles++;
      if (|fall_o) fall_cycles++;
      if (|(rise_o & fall_o)) excl_bad = 1'b1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    cfg_len = 8'd3;
    gpio_i  = 32'hFFFF_FFFF;
`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
    irq_ena = '0;
    irq_clr = '0;
`endif

    // reset with pads high, then release: acceptance after CDC+cfg_len+1 = 6 cycles
    tick(1);
    check("rst_flt", flt_o, 32'h0);
    check("rst_rise", rise_o, 32'h0);
    tick(1);
    check("rst_fall", fall_o, 32'h0);
`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
    check("rst_irq_sts", irq_sts, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
`endif
    rst = 1'b0;
    tick(5);
    check("rel_flt_early", flt_o, 32'h0);
    tick(1);
    check("rel_flt", flt_o, 32'hFFFF_FFFF);
    check("rel_rise", rise_o, 32'hFFFF_FFFF);
    tick(1);
    check("rel_rise_end", rise_o, 32'h0);
    check("rel_flt_hold", flt_o, 32'hFFFF_FFFF);

    gpio_i = '0;
    tick(10);
    check("settle_low", flt_o, 32'h0);

    // glitch of 3 cycles is rejected
    rise_cycles = 0;
    gpio_i[0] = 1'b1;
    tick(3);
    gpio_i[0] = 1'b0;
    tick(10);
    check("glitch3_flt", flt_o, 32'h0);
    check("glitch3_rise", rise_cycles, 32'd0);

    // 4 cycles high is accepted at cycle CDC+4
    gpio_i[0] = 1'b1;
    tick(4);
    gpio_i[0] = 1'b0;
    tick(1);
    check("acc4_early", flt_o, 32'h0);
    tick(1);
    check("acc4_flt", flt_o, 32'h1);
    check("acc4_rise", rise_o, 32'h1);
    tick(1);
    check("acc4_rise_end", rise_o, 32'h0);
    tick(10);
    check("acc4_back_low", flt_o, 32'h0);

    // bounce on bit 3: the 0 restarts the count
    pat = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      gpio_i[3] = pat[i];
      tick(1);
    end
    tick(1);
    check("bounce_early", flt_o, 32'h0);
    tick(1);
    check("bounce_flt", flt_o, 32'h8);
    check("bounce_rise", rise_o, 32'h8);

    // clean fall on bit 5
    gpio_i = 32'h28;
    tick(8);
    check("fall_pre", flt_o, 32'h28);
    rise_cycles = 0;
    fall_cycles = 0;
    gpio_i[5] = 1'b0;
    tick(5);
    check("fall_early", flt_o, 32'h28);
    tick(1);
    check("fall_flt", flt_o, 32'h8);
    check("fall_pulse", fall_o, 32'h20);
    tick(6);
    check("fall_single", fall_cycles, 32'd1);
    check("fall_no_rise", rise_cycles, 32'd0);

    // cfg_len=0: every toggle passes, 3 cycles after the pad
    cfg_len = 8'd0;
    for (int j = 0; j < 10; j++) drv[j] = (j % 2 == 1) ? 32'h5555_AAAA : 32'hAAAA_5555;
    for (int j = 0; j < 10; j++) begin
      gpio_i = drv[j];
      tick(1);
      if (j >= 2) check($sformatf("len0_flt_%0d", j), flt_o, drv[j-2]);
      if (j >= 3) check($sformatf("len0_rise_%0d", j), rise_o, drv[j-2] & ~drv[j-3]);
    end
    cfg_len = 8'd3;
    gpio_i  = '0;
    tick(12);
    check("len0_settle", flt_o, 32'h0);

`ifdef TCB_GPIO_DEBOUNCE_IRQ_EN
    // only bit 0 enabled; set wins over a simultaneous clear
    check("irq_idle", irq_sts, 32'h0);
    irq_ena = 32'h1;
    gpio_i  = 32'h3;
    tick(8);
    check("irq_sts_set", irq_sts, 32'h1);
    check("irq_level", {31'b0, irq}, 32'h1);
    gpio_i[0] = 1'b0;
    tick(6);
    check("irq_fall_edge", fall_o, 32'h1);
    irq_clr = 32'h1;
    tick(1);
    check("irq_set_wins", irq_sts, 32'h1);
    tick(1);
    check("irq_clr_alone", irq_sts, 32'h0);
    check("irq_lag", {31'b0, irq}, 32'h1);
    irq_clr = '0;
    tick(1);
    check("irq_dropped", {31'b0, irq}, 32'h0);
    irq_ena = '0;
    gpio_i  = '0;
    tick(12);
`endif

    // reset while bit 7 is mid-count (cnt=2): no edge survives, fresh count after release
    check("mid_pre", flt_o, 32'h0);
    gpio_i[7] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("mid_rst_flt", flt_o, 32'h0);
    check("mid_rst_rise", rise_o, 32'h0);
    rst = 1'b0;
    rise_cycles = 0;
    tick(5);
    check("mid_no_pulse", rise_cycles, 32'd0);
    check("mid_flt_hold", flt_o, 32'h0);
    tick(1);
    check("mid_recount_flt", flt_o, 32'h80);
    check("mid_recount_rise", rise_o, 32'h80);

    check("rise_fall_excl", {31'b0, excl_bad}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tcb_gpio_debounce
